u_atm_keypad_entry: RTL and testbench
=====================================

// Module: u_atm_keypad_entry
// PURPOSE
// - Upstream stage of the ATM control FSM: turns raw keypad strobes into the FSM's entry inputs.
// - Collects digit keys into a PIN (packed BCD, en_password) or an amount (binary, en_ammount_money).
// - Handles clear/backspace/enter keys and issues a one-cycle enter pulse when an entry is complete.
// PARAMETERS
// - Pass_width   16    PIN output width; must equal 4*PIN_DIGITS
// - AMT_W        16    amount output width (binary)
// - PIN_DIGITS   4     exact digit count required for a PIN entry
// - AMT_DIGITS   5     max digit count accepted for an amount entry
// - TIMEOUT_CYC  1000  idle cycles before auto-clear (only with ATM_KEY_TIMEOUT_EN)
// PORTS
// - clk               in   1           system clock, rising edge
// - rst               in   1           asynchronous reset, active-low
// - key_valid         in   1           level from keypad scanner, high while a key is held
// - key_code          in   4           0-9 digit, 4'hA clear, 4'hB backspace, 4'hC enter, others ignored
// - mode              in   1           0 = PIN entry, 1 = amount entry
// - en_password       out  Pass_width  PIN, first digit in the MS nibble, packed BCD
// - en_ammount_money  out  AMT_W       amount, binary
// - enter             out  1           one-cycle pulse: entry complete, outputs valid
// - digit_count       out  3           digits currently buffered
// - entry_error       out  1           one-cycle pulse on a rejected key
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; key_valid_q 0. Reset mid-entry discards the buffer, no enter pulse.
// - Key event = key_valid & ~key_valid_q, one per press. key_code is sampled on the event cycle.
//   Results register on that edge and are visible the next cycle (latency 1).
// - States:
//   - IDLE: buffer empty.
//   - COLLECT: digit_count >= 1.
//   - DONE: entry latched, outputs held stable.
// - Digit key, PIN mode:
//   - Shift the nibble in from the LSB side; digit_count+1.
//   - At digit_count == PIN_DIGITS: reject, entry_error, buffer unchanged.
// - Digit key, amount mode:
//   - acc_next = acc*10 + d, computed at AMT_W+4 bits.
//   - Reject with entry_error if acc_next > 2^AMT_W-1 or digit_count == AMT_DIGITS.
//   - Otherwise store acc_next and increment digit_count.
// - Backspace:
//   - PIN: shift right one nibble.
//   - Amount: acc/10.
//   - digit_count-1; returns to IDLE at 0.
//   - Backspace in IDLE is ignored (no error).
// - Clear: buffer, digit_count and outputs go to 0; next state IDLE. Valid in any state.
// - Enter:
//   - Accepted if PIN mode with digit_count == PIN_DIGITS, or amount mode with digit_count >= 1.
//   - On accept: enter = 1 for exactly one cycle; state DONE.
//   - Otherwise: entry_error pulse, state unchanged.
// - DONE:
//   - Outputs are held until a new key event.
//   - A digit clears the buffer, then loads that digit (new entry, COLLECT).
//   - Enter in DONE re-pulses enter with the same value.
// - mode change while in COLLECT: buffer cleared to IDLE, no error. A mode change in DONE does not alter the held outputs.
// - enter and entry_error are never high in the same cycle.
// - Unused output is 0: in PIN mode en_ammount_money = 0; in amount mode en_password = 0.
// CONFIGURATION
// - ATM_KEY_TIMEOUT_EN defined:
//   - A 16-bit counter resets on every key event and counts otherwise.
//   - At TIMEOUT_CYC in COLLECT, it acts as a Clear and pulses entry_error once.
//   - The counter saturates; DONE and IDLE are unaffected.
// - ATM_KEY_TIMEOUT_EN undefined: no counter; the buffer persists indefinitely.
// TESTING
// - PIN mode, keys 1,2,3,4,C -> en_password = 16'h1234; one enter pulse 1 cycle after the C event; digit_count = 4.
// - PIN mode, keys 1,2,C -> entry_error pulse; no enter; digit_count stays 2.
// - Amount mode, keys 6,5,5,3,5,C -> 65535 with enter. Then 6,5,5,3,6 -> the fifth digit is rejected with entry_error and acc stays 6553.
// - Amount mode, keys 4,2,B,7,C -> en_ammount_money = 47.
// - Amount mode, keys 9,A,C -> the clear returns to IDLE; C then gives entry_error with value 0. key_valid held high 20 cycles -> only one event.
// - Reset asserted after keys 1,2 -> all outputs 0 asynchronously. With ATM_KEY_TIMEOUT_EN: key 5 then TIMEOUT_CYC idle cycles -> entry_error and digit_count = 0.

Source files
------------

// File: rtl/u_atm_keypad_entry.sv
// Keypad front end for the ATM FSM: collects a BCD PIN or a binary amount and pulses enter.
// Optional idle auto-clear in COLLECT is compiled in with ATM_KEY_TIMEOUT_EN.
module u_atm_keypad_entry #(
    parameter int Pass_width  = 16,
    parameter int AMT_W       = 16,
    parameter int PIN_DIGITS  = 4,
    parameter int AMT_DIGITS  = 5,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_valid,
    input  logic [3:0]            key_code,
    input  logic                  mode,
    output logic [Pass_width-1:0] en_password,
    output logic [AMT_W-1:0]      en_ammount_money,
    output logic                  enter,
    output logic [2:0]            digit_count,
    output logic                  entry_error
);
    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

    localparam logic [2:0]       PIN_N = 3'(PIN_DIGITS);
    localparam logic [2:0]       AMT_N = 3'(AMT_DIGITS);
    localparam logic [AMT_W-1:0] TEN   = AMT_W'(10);

    state_t                r_state, w_nstate;
    logic [Pass_width-1:0] r_pin, w_pin_n, r_pw_o, w_pw_o_n;
    logic [AMT_W-1:0]      r_acc, w_acc_n, r_amt_o, w_amt_o_n;
    logic [2:0]            r_cnt, w_cnt_n;
    logic                  r_enter, w_enter_n, r_err, w_err_n;
    logic                  r_kv_q, r_mode_q;
    logic                  w_ev, w_clear, w_digit;
    logic [AMT_W+3:0]      w_acc_x;

    assign w_ev    = key_valid & ~r_kv_q;
    assign w_digit = (key_code <= 4'd9);
    // acc*10 + d at four extra bits so overflow past AMT_W is visible
    assign w_acc_x = ({4'b0, r_acc} << 3) + ({4'b0, r_acc} << 1) + {{AMT_W{1'b0}}, key_code};

`ifdef ATM_KEY_TIMEOUT_EN
    localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC);
    logic [15:0] r_to_cnt;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                     r_to_cnt <= '0;
        else if (w_ev)                r_to_cnt <= '0;
        else if (r_to_cnt != 16'hFFFF) r_to_cnt <= r_to_cnt + 16'd1;
    end
`endif

    always_comb begin
        w_nstate  = r_state;
        w_pin_n   = r_pin;
        w_acc_n   = r_acc;
        w_cnt_n   = r_cnt;
        w_enter_n = 1'b0;
        w_err_n   = 1'b0;
        w_clear   = 1'b0;
        if (r_state == S_COLLECT && mode != r_mode_q) begin
            w_clear = 1'b1;
        end else if (w_ev) begin
            if (key_code == 4'hA) begin
                w_clear = 1'b1;
            end else if (key_code == 4'hB) begin
                if (r_state == S_COLLECT) begin
                    w_pin_n = {4'h0, r_pin[Pass_width-1:4]};
                    w_acc_n = r_acc / TEN;
                    w_cnt_n = r_cnt - 3'd1;
                    if (r_cnt == 3'd1) w_nstate = S_IDLE;
                end
            end else if (key_code == 4'hC) begin
                if (r_state == S_DONE) begin
                    w_enter_n = 1'b1;
                end else if (mode ? (r_cnt != 3'd0) : (r_cnt == PIN_N)) begin
                    w_enter_n = 1'b1;
                    w_nstate  = S_DONE;
                end else begin
                    w_err_n = 1'b1;
                end
            end else if (w_digit) begin
                if (r_state == S_DONE) begin
                    // a digit after a completed entry starts a fresh one
                    w_pin_n  = mode ? '0 : {{(Pass_width-4){1'b0}}, key_code};
                    w_acc_n  = mode ? {{(AMT_W-4){1'b0}}, key_code} : '0;
                    w_cnt_n  = 3'd1;
                    w_nstate = S_COLLECT;
                end else if (mode) begin
                    if (r_cnt == AMT_N || w_acc_x[AMT_W+3:AMT_W] != 4'h0) begin
                        w_err_n = 1'b1;
                    end else begin
                        w_acc_n  = w_acc_x[AMT_W-1:0];
                        w_cnt_n  = r_cnt + 3'd1;
                        w_nstate = S_COLLECT;
                    end
                end else if (r_cnt == PIN_N) begin
                    w_err_n = 1'b1;
                end else begin
                    w_pin_n  = {r_pin[Pass_width-5:0], key_code};
                    w_cnt_n  = r_cnt + 3'd1;
                    w_nstate = S_COLLECT;
                end
            end
        end
`ifdef ATM_KEY_TIMEOUT_EN
        else if (r_state == S_COLLECT && r_to_cnt == TO_LIM) begin
            w_clear = 1'b1;
            w_err_n = 1'b1;
        end
`endif
        if (w_clear) begin
            w_pin_n  = '0;
            w_acc_n  = '0;
            w_cnt_n  = 3'd0;
            w_nstate = S_IDLE;
        end

        // live buffer while collecting, frozen copy once DONE
        if (w_nstate == S_DONE && r_state == S_DONE) begin
            w_pw_o_n  = r_pw_o;
            w_amt_o_n = r_amt_o;
        end else if (w_nstate == S_DONE) begin
            w_pw_o_n  = mode ? '0 : r_pin;
            w_amt_o_n = mode ? r_acc : '0;
        end else begin
            w_pw_o_n  = mode ? '0 : w_pin_n;
            w_amt_o_n = mode ? w_acc_n : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_pin    <= '0;
            r_acc    <= '0;
            r_cnt    <= 3'd0;
            r_pw_o   <= '0;
            r_amt_o  <= '0;
            r_enter  <= 1'b0;
            r_err    <= 1'b0;
            r_kv_q   <= 1'b0;
            r_mode_q <= 1'b0;
        end else begin
            r_state  <= w_nstate;
            r_pin    <= w_pin_n;
            r_acc    <= w_acc_n;
            r_cnt    <= w_cnt_n;
            r_pw_o   <= w_pw_o_n;
            r_amt_o  <= w_amt_o_n;
            r_enter  <= w_enter_n;
            r_err    <= w_err_n;
            r_kv_q   <= key_valid;
            r_mode_q <= mode;
        end
    end

    assign en_password      = r_pw_o;
    assign en_ammount_money = r_amt_o;
    assign enter            = r_enter;
    assign digit_count      = r_cnt;
    assign entry_error      = r_err;
endmodule

// File: tb/tb_u_atm_keypad_entry.sv
// Directed bench for u_atm_keypad_entry (default build, idle timeout disabled).
module tb_u_atm_keypad_entry;
    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        mode;
    logic [15:0] en_password;
    logic [15:0] en_ammount_money;
    logic        enter;
    logic [2:0]  digit_count;
    logic        entry_error;
    int          checks = 0;
    int          errors = 0;

    u_atm_keypad_entry dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code), .mode(mode),
        .en_password(en_password), .en_ammount_money(en_ammount_money), .enter(enter),
        .digit_count(digit_count), .entry_error(entry_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // one press: key high for `hold` cycles; returns at the negedge after the event edge
    task automatic press(input logic [3:0] k, input int hold = 1);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = k;
        repeat (hold) @(negedge clk);
        key_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0; key_valid = 1'b0; key_code = 4'h0; mode = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_pw", en_password, 0);
        chk("rst_amt", en_ammount_money, 0);
        chk("rst_cnt", digit_count, 0);
        chk("rst_enter", enter, 0);
        chk("rst_err", entry_error, 0);
        rst = 1'b1;

        // PIN 1,2,3,4,C
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        chk("pin4_cnt", digit_count, 4);
        chk("pin4_live", en_password, 16'h1234);
        press(4'hC);
        chk("pin_enter", enter, 1);
        chk("pin_err0", entry_error, 0);
        chk("pin_val", en_password, 16'h1234);
        chk("pin_cnt", digit_count, 4);
        chk("pin_amt0", en_ammount_money, 0);
        @(negedge clk);
        chk("pin_enter_1cyc", enter, 0);
        press(4'hA);
        chk("clr_pw", en_password, 0);
        chk("clr_cnt", digit_count, 0);

        // PIN short entry, then overfill
        press(4'd1); press(4'd2); press(4'hC);
        chk("pin_short_err", entry_error, 1);
        chk("pin_short_enter", enter, 0);
        chk("pin_short_cnt", digit_count, 2);
        press(4'd3); press(4'd4); press(4'd5);
        chk("pin_over_err", entry_error, 1);
        chk("pin_over_val", en_password, 16'h1234);
        chk("pin_over_cnt", digit_count, 4);
        press(4'hA);

        // amount 65535, then overflow on new entry
        mode = 1'b1;
        press(4'd6); press(4'd5); press(4'd5); press(4'd3); press(4'd5); press(4'hC);
        chk("amt_max_enter", enter, 1);
        chk("amt_max_val", en_ammount_money, 65535);
        chk("amt_pw0", en_password, 0);
        press(4'd6);
        chk("amt_new_cnt", digit_count, 1);
        chk("amt_new_val", en_ammount_money, 6);
        press(4'd5); press(4'd5); press(4'd3); press(4'd6);
        chk("amt_ovf_err", entry_error, 1);
        chk("amt_ovf_val", en_ammount_money, 6553);
        chk("amt_ovf_cnt", digit_count, 4);
        press(4'hA);

        // 4,2,B,7,C -> 47
        press(4'd4); press(4'd2); press(4'hB);
        chk("bs_val", en_ammount_money, 4);
        chk("bs_cnt", digit_count, 1);
        press(4'd7); press(4'hC);
        chk("amt47_enter", enter, 1);
        chk("amt47_val", en_ammount_money, 47);
        press(4'hA);

        // 9,A,C -> error with value 0
        press(4'd9); press(4'hA);
        chk("clr9_cnt", digit_count, 0);
        press(4'hC);
        chk("idle_c_err", entry_error, 1);
        chk("idle_c_enter", enter, 0);
        chk("idle_c_val", en_ammount_money, 0);

        // held key counts once
        press(4'd7, 20);
        chk("hold_cnt", digit_count, 1);
        chk("hold_val", en_ammount_money, 7);
        press(4'hA);

        // re-enter in DONE
        press(4'd8); press(4'hC);
        @(negedge clk);
        press(4'hC);
        chk("re_enter", enter, 1);
        chk("re_enter_val", en_ammount_money, 8);
        press(4'hA);

        // mode change mid-entry clears silently
        press(4'd3);
        @(negedge clk);
        mode = 1'b0;
        @(negedge clk);
        chk("mchg_cnt", digit_count, 0);
        chk("mchg_err", entry_error, 0);
        chk("mchg_pw", en_password, 0);

        // backspace in IDLE ignored
        press(4'hB);
        chk("bs_idle_err", entry_error, 0);
        chk("bs_idle_cnt", digit_count, 0);

        // async reset mid entry
        press(4'd1); press(4'd2);
        chk("pre_rst_pw", en_password, 16'h0012);
        #2 rst = 1'b0;
        #1;
        chk("arst_pw", en_password, 0);
        chk("arst_cnt", digit_count, 0);
        chk("arst_enter", enter, 0);
        @(negedge clk);
        rst = 1'b1;

        // mode change in DONE keeps held outputs
        press(4'd9); press(4'd8); press(4'd7); press(4'd6); press(4'hC);
        chk("done_enter", enter, 1);
        mode = 1'b1;
        repeat (2) @(negedge clk);
        chk("done_hold_pw", en_password, 16'h9876);
        chk("done_hold_amt", en_ammount_money, 0);
        chk("done_hold_cnt", digit_count, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
